// File: rtl/digital_clock_pkg.sv
// Shared encodings and pattern timing for the alarm/chime beeper.
// States double as active_src codes where they overlap.
package digital_clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHIME  = 2'd1,
      ST_ALARM  = 2'd2,
      ST_SNOOZE = 2'd3
   } state_e;

   localparam logic [1:0] SRC_NONE   = 2'd0;
   localparam logic [1:0] SRC_CHIME  = 2'd1;
   localparam logic [1:0] SRC_ALARM  = 2'd2;
   localparam logic [1:0] SRC_SNOOZE = 2'd3;

   localparam int CHIME_ON_MS     = 100;
   localparam int CHIME_PERIOD_MS = 2 * CHIME_ON_MS;
   localparam int ALARM_ON_MS     = 500;
   localparam int SEC_MS          = 1000;

   function automatic logic [1:0] src_of(state_e s);
      logic [1:0] r;
      r = SRC_NONE;
      case (s)
         ST_CHIME:  r = SRC_CHIME;
         ST_ALARM:  r = SRC_ALARM;
         ST_SNOOZE: r = SRC_SNOOZE;
         default:   r = SRC_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Millisecond prescaler and square-wave tone divider.
// clr restarts both so every pattern begins phase-aligned.
module beep_tone_gen
   import digital_clock_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TONE_HZ = 2_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic ms_tick,
   output logic tone
);

   localparam int MS_DIV = CLK_HZ / 1000;
   localparam int HALF   = CLK_HZ / (2 * TONE_HZ);
   localparam int MW     = $clog2(MS_DIV);
   localparam int HW     = (HALF > 1) ? $clog2(HALF) : 1;

   logic [MW-1:0] ms_cnt_q;
   logic [HW-1:0] half_cnt_q;
   logic          tone_q;

   assign ms_tick = (ms_cnt_q == MW'(MS_DIV - 1));
   assign tone    = tone_q;

   // free-running ms prescaler and tone toggle, restarted by clr
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         ms_cnt_q   <= '0;
         half_cnt_q <= '0;
         tone_q     <= 1'b0;
      end else begin
         if (ms_tick) ms_cnt_q <= '0;
         else         ms_cnt_q <= ms_cnt_q + MW'(1);
         if (half_cnt_q == HW'(HALF - 1)) begin
            half_cnt_q <= '0;
            tone_q     <= ~tone_q;
         end else begin
            half_cnt_q <= half_cnt_q + HW'(1);
         end
      end
   end

endmodule

// File: rtl/alarm_beep_scheduler.sv
// Beep owner: arbitrates alarm/chime patterns onto the buzzer.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_beep_scheduler
   import digital_clock_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TONE_HZ     = 2_000,
   parameter int ALARM_SEC   = 60,
   parameter int CHIME_BEEPS = 2,
   parameter int SNOOZE_SEC  = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alarm_req,
   input  logic       chime_req,
   input  logic       stop_pulse,
   input  logic       snooze_pulse,
   output logic       beep,
   output logic       busy,
   output logic [1:0] active_src
);

   state_e      state_q, state_d;
   logic        alarm_q;
   logic [9:0]  ms_q;
   logic [8:0]  cnt_q;
   logic        beep_q, busy_q;
   logic [1:0]  src_q;
   logic        ms_tick, tone;
   logic        rise, last_ms, wrap, enter, pat_on;

`ifndef ALARM_SNOOZE_EN
   logic unused_cfg;
   assign unused_cfg = snooze_pulse | (SNOOZE_SEC == 0);
`endif

   beep_tone_gen #(
      .CLK_HZ  (CLK_HZ),
      .TONE_HZ (TONE_HZ)
   ) u_tone (
      .clk     (clk),
      .rst     (rst),
      .clr     (enter),
      .ms_tick (ms_tick),
      .tone    (tone)
   );

   // next state, pattern gate and period-wrap decode
   always_comb begin
      rise    = alarm_req & ~alarm_q;
      last_ms = (state_q == ST_CHIME)
              ? (ms_q == 10'(CHIME_PERIOD_MS - 1))
              : (ms_q == 10'(SEC_MS - 1));
      wrap    = ms_tick & last_ms;
      pat_on  = ((state_q == ST_CHIME) &&
                 (ms_q < 10'(CHIME_ON_MS))) ||
                ((state_q == ST_ALARM) &&
                 (ms_q < 10'(ALARM_ON_MS)));
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rise)           state_d = ST_ALARM;
            else if (chime_req) state_d = ST_CHIME;
         end
         ST_CHIME: begin
            if (rise)            state_d = ST_ALARM;
            else if (stop_pulse) state_d = ST_IDLE;
            else if (wrap && cnt_q == 9'(CHIME_BEEPS - 1))
               state_d = ST_IDLE;
         end
         ST_ALARM: begin
            if (stop_pulse) state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
            else if (snooze_pulse) state_d = ST_SNOOZE;
`endif
            else if (wrap && cnt_q == 9'(ALARM_SEC - 1))
               state_d = ST_IDLE;
         end
`ifdef ALARM_SNOOZE_EN
         ST_SNOOZE: begin
            if (stop_pulse) state_d = ST_IDLE;
            else if (rise)  state_d = ST_ALARM;
            else if (wrap && cnt_q == 9'(SNOOZE_SEC - 1))
               state_d = ST_ALARM;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      enter = (state_d != state_q);
   end

   // FSM state, pattern counters and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         alarm_q <= 1'b0;
         ms_q    <= '0;
         cnt_q   <= '0;
         beep_q  <= 1'b0;
         busy_q  <= 1'b0;
         src_q   <= SRC_NONE;
      end else begin
         alarm_q <= alarm_req;
         state_q <= state_d;
         if (enter || state_q == ST_IDLE) begin
            ms_q  <= '0;
            cnt_q <= '0;
         end else if (ms_tick) begin
            if (wrap) begin
               ms_q  <= '0;
               cnt_q <= cnt_q + 9'd1;
            end else begin
               ms_q  <= ms_q + 10'd1;
            end
         end
         beep_q <= tone & pat_on & ~enter;
         busy_q <= (state_d != ST_IDLE);
         src_q  <= src_of(state_d);
      end
   end

   assign beep       = beep_q;
   assign busy       = busy_q;
   assign active_src = src_q;

endmodule
